// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one recoding step per clock, full-width signed product.
// Optional busy output is enabled by defining BOOTH_BUSY_EN.
module booth_multiplier #(
    parameter int DATAWIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_overall,
    input  logic                          rst_vals,
    input  logic                          start,
    input  logic signed [DATAWIDTH-1:0]   a,
    input  logic signed [DATAWIDTH-1:0]   b,
    output logic signed [2*DATAWIDTH-1:0] product,
    output logic                          done
`ifdef BOOTH_BUSY_EN
    ,
    output logic                          busy
`endif
);

    localparam int CNT_W = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state_q, state_d;
    logic signed [DATAWIDTH:0]       acc_q, acc_d;
    logic signed [DATAWIDTH:0]       m_q, m_d;
    logic        [DATAWIDTH-1:0]     q_q, q_d;
    logic                            qm1_q, qm1_d;
    logic        [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [2*DATAWIDTH-1:0]   product_q, product_d;
    logic                            done_q, done_d;
`ifdef BOOTH_BUSY_EN
    logic                            busy_q, busy_d;
`endif

    // One Booth step: add/subtract M by {Q[0],Q_-1}, then arithmetic shift of {A,Q,Q_-1}.
    function automatic logic [2*DATAWIDTH+1:0] booth_step(
        input logic signed [DATAWIDTH:0]   acc,
        input logic signed [DATAWIDTH:0]   m,
        input logic        [DATAWIDTH-1:0] q,
        input logic                        qm1
    );
        logic signed [DATAWIDTH:0] sum;
        case ({q[0], qm1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        return {sum[DATAWIDTH], sum, q};
    endfunction

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        if (rst_vals) begin
            state_d   = IDLE;
            acc_d     = '0;
            m_d       = '0;
            q_d       = '0;
            qm1_d     = 1'b0;
            cnt_d     = '0;
            product_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_d     = {a[DATAWIDTH-1], a};
                        q_d     = b;
                        acc_d   = '0;
                        qm1_d   = 1'b0;
                        cnt_d   = CNT_W'(DATAWIDTH);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    {acc_d, q_d, qm1_d} = booth_step(acc_q, m_q, q_q, qm1_q);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    product_d = {acc_q[DATAWIDTH-1:0], q_q};
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef BOOTH_BUSY_EN
        // Stays high through the cycle in which the done pulse is visible.
        busy_d = (state_d != IDLE) || done_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_overall) begin
        if (!rst_overall) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
`ifdef BOOTH_BUSY_EN
            busy_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
`ifdef BOOTH_BUSY_EN
            busy_q    <= busy_d;
`endif
        end
    end

    assign product = product_q;
    assign done    = done_q;
`ifdef BOOTH_BUSY_EN
    assign busy    = busy_q;
`endif

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and random checks of booth_multiplier: reset, signs, edge operands, ignore, abort, latency.
module tb_booth_multiplier;

    localparam int DW = 8;

    logic                   clk = 1'b0;
    logic                   rst_overall;
    logic                   rst_vals;
    logic                   start;
    logic signed [DW-1:0]   a;
    logic signed [DW-1:0]   b;
    logic signed [2*DW-1:0] product;
    logic                   done;
`ifdef BOOTH_BUSY_EN
    logic                   busy;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    booth_multiplier #(.DATAWIDTH(DW)) dut (
        .clk         (clk),
        .rst_overall (rst_overall),
        .rst_vals    (rst_vals),
        .start       (start),
        .a           (a),
        .b           (b),
        .product     (product),
        .done        (done)
`ifdef BOOTH_BUSY_EN
        ,
        .busy        (busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse; optionally poke start=(1,1) mid-run.
    task automatic run_op(input logic signed [DW-1:0] ta, input logic signed [DW-1:0] tb_v,
                          input longint exp, input string tag, input bit poke);
        int lat;
        int pulses;
        lat    = 0;
        pulses = 0;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef BOOTH_BUSY_EN
        check({tag, " busy@0"}, busy, 1);
`endif
        for (int k = 1; k <= DW + 2; k++) begin
            if (poke && k == 3) begin
                @(negedge clk);
                a     = 1;
                b     = 1;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                pulses++;
                if (lat == 0) lat = k;
            end
`ifdef BOOTH_BUSY_EN
            check({tag, " busy"}, busy, (k <= DW + 1) ? 1 : 0);
`endif
        end
        check({tag, " latency"}, lat, DW + 1);
        check({tag, " pulses"}, pulses, 1);
        check({tag, " product"}, product, exp);
    endtask

    initial begin
        int pulses;
        logic signed [DW-1:0] ra;
        logic signed [DW-1:0] rb;

        rst_overall = 1'b0;
        rst_vals    = 1'b0;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        #3;
        check("rst product", product, 0);
        check("rst done", done, 0);
`ifdef BOOTH_BUSY_EN
        check("rst busy", busy, 0);
`endif
        @(negedge clk);
        rst_overall = 1'b1;
        rst_vals    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("clr product", product, 0);
        check("clr done", done, 0);
        @(negedge clk);
        rst_vals = 1'b0;

        run_op(5, 3, 15, "p*p", 1'b0);
        run_op(-5, 3, -15, "n*p", 1'b0);
        run_op(5, -3, -15, "p*n", 1'b0);
        run_op(-5, -3, 15, "n*n", 1'b0);
        run_op(0, 12, 0, "0*12", 1'b0);
        run_op(12, 0, 0, "12*0", 1'b0);
        run_op(127, 2, 254, "127*2", 1'b0);
        run_op(-128, 2, -256, "-128*2", 1'b0);
        run_op(127, -128, -16256, "127*-128", 1'b0);
        run_op(-128, -128, 16384, "-128*-128", 1'b0);

        // Start during RUN is ignored; result then holds while idle.
        run_op(-7, 11, -77, "ignore", 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("hold product", product, -77);
        check("hold done", done, 0);

        // Asynchronous reset clears the held result without a clock edge.
        @(negedge clk);
        #2;
        rst_overall = 1'b0;
        #1;
        check("async product", product, 0);
        check("async done", done, 0);
        @(negedge clk);
        rst_overall = 1'b1;
        run_op(6, 6, 36, "post-rst", 1'b0);

        // Abort mid-run with rst_vals.
        @(negedge clk);
        a     = 100;
        b     = 100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_vals = 1'b1;
        @(posedge clk);
        #1;
        check("abort product", product, 0);
        @(negedge clk);
        rst_vals = 1'b0;
        pulses   = 0;
        for (int k = 0; k < DW + 4; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort pulses", pulses, 0);
        check("abort product hold", product, 0);
        run_op(7, -9, -63, "after abort", 1'b0);

        // Start held across DONE->IDLE launches the next operation at once.
        @(negedge clk);
        a     = 3;
        b     = 4;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= DW + 1; k++) begin
            @(posedge clk);
            #1;
        end
        check("b2b done1", done, 1);
        check("b2b product1", product, 12);
        a = -2;
        b = 6;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= DW + 1; k++) begin
            @(posedge clk);
            #1;
        end
        check("b2b done2", done, 1);
        check("b2b product2", product, -12);
        @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            run_op(ra, rb, longint'(ra) * longint'(rb), "random", 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
